pc_unit: RTL and testbench

//   Parametrised program-counter unit for the single-cycle RV32 core; the next generation of the basic PC register.

---
 rtl/pc_unit.sv | 163 ++++++++++++++++
 tb/tb_pc_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the single-cycle RV32 core.
// Holds the PC and selects the next PC internally (sequential, branch, JALR, JAL, trap).
// Includes a post-reset boot hold, stall, misaligned-target trapping and a retire counter.
// Optional feature macro: PC_HISTORY_EN adds a circular buffer of recent PCs (hist_idx/hist_pc).
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INC          = 4,
  parameter int              ALIGN_LOG2   = 2,
  parameter int              BOOT_CYCLES  = 2,
  parameter int              CNT_W        = 32,
  parameter int              HIST_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [1:0]                    next_sel,
  input  logic                          branch_taken,
  input  logic [XLEN-1:0]               target,
  input  logic                          trap_req,
  output logic [XLEN-1:0]               pc_out,
  output logic [XLEN-1:0]               pc_plus_inc,
  output logic                          booting,
  output logic                          misalign_fault,
  output logic [CNT_W-1:0]              retire_cnt
`ifdef PC_HISTORY_EN
  ,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               hist_pc
`endif
);

  localparam int BCW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

  state_t          r_state;
  state_t          w_stateNext;
  logic [BCW-1:0]  r_bootCnt;
  logic [BCW-1:0]  w_bootCntNext;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;
  logic [CNT_W-1:0] r_retireCnt;

  logic            w_advance;
  logic            w_isJump;
  logic [XLEN-1:0] w_target;
  logic            w_misalign;
  logic [XLEN-1:0] w_pcPlusInc;
  logic [XLEN-1:0] w_nextPc;

  assign w_advance   = (r_state == ST_RUN) && en;
  assign w_pcPlusInc = r_pc + XLEN'(INC);

  // Boot sequencing: count edges in BOOT, move to RUN on the last one; RUN is terminal.
  always_comb begin
    w_stateNext   = r_state;
    w_bootCntNext = r_bootCnt;
    case (r_state)
      ST_BOOT: begin
        if (r_bootCnt == BOOT_LAST) begin
          w_stateNext = ST_RUN;
        end else begin
          w_bootCntNext = r_bootCnt + BCW'(1);
        end
      end
      default: begin
        w_stateNext = r_state;
      end
    endcase
  end

  // State register and boot counter, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RESET_STATE;
      r_bootCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_bootCnt <= w_bootCntNext;
    end
  end

  // Decode the redirect kind; JALR clears bit 0 of the target before the alignment check.
  always_comb begin
    w_isJump = 1'b0;
    w_target = target;
    case (next_sel)
      2'b01: w_isJump = branch_taken;
      2'b10: begin
        w_isJump = 1'b1;
        w_target = target & ~XLEN'(1);
      end
      2'b11: w_isJump = 1'b1;
      default: w_isJump = 1'b0;
    endcase
  end

  assign w_misalign = w_isJump && (w_target[ALIGN_LOG2-1:0] != '0);

  // Next-PC priority: trap request, then redirect (misaligned redirect traps), then sequential.
  always_comb begin
    w_nextPc = w_pcPlusInc;
    if (trap_req) begin
      w_nextPc = TRAP_VECTOR;
    end else if (w_isJump) begin
      w_nextPc = w_misalign ? TRAP_VECTOR : w_target;
    end
  end

  // PC, fault pulse and retire counter only move on RUN edges with en high; a stall clears the fault pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_VECTOR;
      r_fault     <= 1'b0;
      r_retireCnt <= '0;
    end else if (w_advance) begin
      r_pc        <= w_nextPc;
      r_fault     <= !trap_req && w_misalign;
      r_retireCnt <= r_retireCnt + CNT_W'(1);
    end else begin
      r_fault     <= 1'b0;
    end
  end

`ifdef PC_HISTORY_EN
  localparam int HIST_W = $clog2(HIST_DEPTH);

  logic [XLEN-1:0]   r_hist [HIST_DEPTH];
  logic [HIST_W-1:0] r_wrPtr;
  logic [HIST_W-1:0] w_rdIdx;

  // Push the outgoing PC on every advance; the oldest entry is overwritten once the buffer is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_hist[i] <= RESET_VECTOR;
      end
    end else if (w_advance) begin
      r_hist[r_wrPtr] <= r_pc;
      r_wrPtr         <= r_wrPtr + HIST_W'(1);
    end
  end

  assign w_rdIdx = r_wrPtr - HIST_W'(1) - hist_idx;
  assign hist_pc = r_hist[w_rdIdx];
`endif

  assign pc_out         = r_pc;
  assign pc_plus_inc    = w_pcPlusInc;
  assign booting        = (r_state == ST_BOOT);
  assign misalign_fault = r_fault;
  assign retire_cnt     = r_retireCnt;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default parameters plus a CNT_W=4 copy for counter wrap).
// History checks are compiled in when PC_HISTORY_EN is defined.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [1:0]  next_sel;
  logic        branch_taken;
  logic [31:0] target;
  logic        trap_req;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic        booting;
  logic        misalign_fault;
  logic [31:0] retire_cnt;
  logic [31:0] pc4;
  logic [31:0] pcPlus4;
  logic        booting4;
  logic        fault4;
  logic [3:0]  retireCnt4;
`ifdef PC_HISTORY_EN
  logic [2:0]  hist_idx;
  logic [31:0] hist_pc;
  logic [2:0]  histIdx4;
  logic [31:0] histPc4;
`endif

  int testCount = 0;
  int failCount = 0;
  int expCnt    = 0;

  pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .next_sel       (next_sel),
    .branch_taken   (branch_taken),
    .target         (target),
    .trap_req       (trap_req),
    .pc_out         (pc_out),
    .pc_plus_inc    (pc_plus_inc),
    .booting        (booting),
    .misalign_fault (misalign_fault),
    .retire_cnt     (retire_cnt)
`ifdef PC_HISTORY_EN
    ,
    .hist_idx       (hist_idx),
    .hist_pc        (hist_pc)
`endif
  );

  pc_unit #(.CNT_W(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .next_sel       (next_sel),
    .branch_taken   (branch_taken),
    .target         (target),
    .trap_req       (trap_req),
    .pc_out         (pc4),
    .pc_plus_inc    (pcPlus4),
    .booting        (booting4),
    .misalign_fault (fault4),
    .retire_cnt     (retireCnt4)
`ifdef PC_HISTORY_EN
    ,
    .hist_idx       (histIdx4),
    .hist_pc        (histPc4)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic e, input logic [1:0] sel, input logic bt,
                               input logic [31:0] tgt, input logic trap);
    en           = e;
    next_sel     = sel;
    branch_taken = bt;
    target       = tgt;
    trap_req     = trap;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkCnt(input string tag);
    logic [31:0] e32;
    e32 = expCnt;
    checkOutput({tag, "_cnt"}, retire_cnt, e32);
    checkOutput({tag, "_cnt4"}, {28'd0, retireCnt4}, {28'd0, e32[3:0]});
  endtask

  task automatic stepCheck(input string tag, input logic [31:0] expPc, input logic expFault);
    tick();
    expCnt++;
    checkOutput({tag, "_pc"}, pc_out, expPc);
    checkOutput({tag, "_fault"}, {31'd0, misalign_fault}, {31'd0, expFault});
  endtask

  initial begin
`ifdef PC_HISTORY_EN
    hist_idx = '0;
    histIdx4 = '0;
`endif
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0);

    // Reset held for three edges
    tick(); tick(); tick();
    checkOutput("reset_pc", pc_out, 32'h0);
    checkOutput("reset_booting", {31'd0, booting}, 32'd1);
    checkOutput("reset_fault", {31'd0, misalign_fault}, 32'd0);
    checkCnt("reset");
    checkOutput("reset_plus", pc_plus_inc, 32'h4);

    // Release; en is ignored during the two boot edges
    reset = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("boot1_pc", pc_out, 32'h0);
    checkOutput("boot1_booting", {31'd0, booting}, 32'd1);
    tick();
    checkOutput("boot2_pc", pc_out, 32'h0);
    checkOutput("boot2_booting", {31'd0, booting}, 32'd0);
    checkCnt("boot2");

    stepCheck("seq1", 32'h4, 1'b0);
    stepCheck("seq2", 32'h8, 1'b0);
    checkOutput("seq2_plus", pc_plus_inc, 32'hC);
    checkCnt("seq2");

    // Branch taken / not taken
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h40, 1'b0);
    stepCheck("br_taken", 32'h40, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h8, 1'b0);
    stepCheck("jal_back", 32'h8, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h40, 1'b0);
    stepCheck("br_not", 32'hC, 1'b0);

    // JALR clears bit 0; misaligned JAL traps with a one-cycle fault pulse
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h81, 1'b0);
    stepCheck("jalr", 32'h80, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h42, 1'b0);
    stepCheck("jal_mis", 32'h100, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    stepCheck("after_mis", 32'h104, 1'b0);

    // Misaligned taken branch, then a stall clears the fault pulse
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h6, 1'b0);
    stepCheck("br_mis", 32'h100, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("stall_clr_pc", pc_out, 32'h100);
    checkOutput("stall_clr_fault", {31'd0, misalign_fault}, 32'd0);
    checkCnt("stall_clr");

    // Trap has top priority, and suppresses the fault even with a misaligned target
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h200, 1'b1);
    stepCheck("trap", 32'h100, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h203, 1'b1);
    stepCheck("trap_mis", 32'h100, 1'b0);

    // Stall for three edges with trap and target active
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h300, 1'b1);
    tick(); tick(); tick();
    checkOutput("stall_pc", pc_out, 32'h100);
    checkCnt("stall");

    // Wrap of pc + INC
    applyStimulus(1'b1, 2'b11, 1'b0, 32'hFFFF_FFFC, 1'b0);
    stepCheck("to_top", 32'hFFFF_FFFC, 1'b0);
    checkOutput("top_plus", pc_plus_inc, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    stepCheck("wrap", 32'h0, 1'b0);
    checkCnt("wrap");

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    expCnt = 0;
    checkOutput("areset_pc", pc_out, 32'h0);
    checkOutput("areset_booting", {31'd0, booting}, 32'd1);
    checkCnt("areset");
    tick();
    reset = 1'b1;
    tick(); tick();
    checkOutput("reboot_booting", {31'd0, booting}, 32'd0);

    // Three advances 0 -> 4 -> 8 -> 0xC
    for (int i = 1; i <= 3; i++) begin
      stepCheck("hist_adv", 32'(4 * i), 1'b0);
    end
`ifdef PC_HISTORY_EN
    hist_idx = 3'd0;
    #1;
    checkOutput("hist_idx0", hist_pc, 32'h8);
    hist_idx = 3'd2;
    #1;
    checkOutput("hist_idx2", hist_pc, 32'h0);
`endif

    // Thirteen more advances: sixteen in total since reset, CNT_W=4 counter wraps to 0
    for (int i = 4; i <= 16; i++) begin
      stepCheck("cnt_adv", 32'(4 * i), 1'b0);
      if (i == 15) begin
        checkCnt("cnt15");
      end
    end
    checkOutput("cnt16_cnt4", {28'd0, retireCnt4}, 32'd0);
    checkOutput("cnt16_cnt", retire_cnt, 32'd16);

`ifdef PC_HISTORY_EN
    hist_idx = 3'd0;
    #1;
    checkOutput("hist_full0", hist_pc, 32'h3C);
    // Mid-run reset clears every history entry
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      hist_idx = 3'(i);
      #1;
      checkOutput("hist_reset", hist_pc, 32'h0);
    end
    reset = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
